// File: rtl/riscv_mul_pipe.sv
// ============================================================================
// riscv_mul_pipe : fully pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU/MULW)
// Revision 1.0
// ============================================================================
`default_nettype none

`ifndef RV32I
`define RV32I 2'b01
`endif

module riscv_mul_pipe #(
   parameter int XLEN    = 64,
   parameter int ILEN    = 64,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ex_stall,
   input  logic             ex_flush,
   input  logic             id_bubble,
   input  logic [ILEN-1:0]  id_instr,
   input  logic [TAG_W-1:0] id_tag,
   input  logic [XLEN-1:0]  opA,
   input  logic [XLEN-1:0]  opB,
   input  logic [1:0]       st_xlen,
   output logic             mul_bubble,
   output logic [XLEN-1:0]  mul_r,
   output logic [TAG_W-1:0] mul_tag,
   output logic             mul_busy
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_MULW   = 3'd4;

   generate
      if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
         $error("riscv_mul_pipe: LATENCY must be in 1..4");
      end
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("riscv_mul_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   logic [6:0]      func7;
   logic [2:0]      func3;
   logic [4:0]      opcode;
   logic            is_rr;
   logic            is_w;
   logic            issue;
   logic [2:0]      dec_op;
   logic [XLEN-1:0] a_src, b_src, mag_a, mag_b;
   logic            a_sgn, b_sgn, neg;
   logic            unused_instr;

   assign func7        = id_instr[31:25];
   assign func3        = id_instr[14:12];
   assign opcode       = id_instr[6:2];
   assign unused_instr = ^id_instr;

   always_comb begin
      is_rr  = (func7 == 7'b0000001) && (opcode == 5'b01100) && !func3[2];
      is_w   = (XLEN == 64) && (func7 == 7'b0000001) && (opcode == 5'b01110)
               && (func3 == 3'b000) && (st_xlen != `RV32I);
      dec_op = is_w ? OP_MULW : {1'b0, func3[1:0]};
   end

   assign issue = !id_bubble && (is_rr || is_w) && !ex_stall && !ex_flush;

   // One unsigned array serves every variant: signs are folded out here and back in at the end
   always_comb begin
      a_src = opA;
      b_src = opB;
      if (dec_op == OP_MULW) begin
         a_src = XLEN'(signed'(opA[31:0]));
         b_src = XLEN'(signed'(opB[31:0]));
      end
      a_sgn = (dec_op != OP_MULHU) && a_src[XLEN-1];
      b_sgn = ((dec_op == OP_MUL) || (dec_op == OP_MULH) || (dec_op == OP_MULW)) && b_src[XLEN-1];
      mag_a = a_sgn ? -a_src : a_src;
      mag_b = b_sgn ? -b_src : b_src;
      neg   = a_sgn ^ b_sgn;
   end

   logic             last_vld;
   logic             last_neg;
   logic [2:0]       last_op;
   logic [TAG_W-1:0] last_tag;
   logic [XLEN-1:0]  last_a, last_b;
   logic             stage_busy;

   generate
      if (LATENCY > 1) begin : g_stages
         logic [LATENCY-1:1] vld;
         logic               sneg [1:LATENCY-1];
         logic [2:0]         sop  [1:LATENCY-1];
         logic [TAG_W-1:0]   stag [1:LATENCY-1];
         logic [XLEN-1:0]    sa   [1:LATENCY-1];
         logic [XLEN-1:0]    sb   [1:LATENCY-1];

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               vld <= '0;
               for (int i = 1; i < LATENCY; i++) begin
                  sneg[i] <= 1'b0;
                  sop[i]  <= OP_MUL;
                  stag[i] <= '0;
                  sa[i]   <= '0;
                  sb[i]   <= '0;
               end
            end else if (ex_flush) begin
               vld <= '0;
            end else if (!ex_stall) begin
               vld[1]  <= issue;
               sneg[1] <= neg;
               sop[1]  <= dec_op;
               stag[1] <= id_tag;
               sa[1]   <= mag_a;
               sb[1]   <= mag_b;
               for (int i = 2; i < LATENCY; i++) begin
                  vld[i]  <= vld[i-1];
                  sneg[i] <= sneg[i-1];
                  sop[i]  <= sop[i-1];
                  stag[i] <= stag[i-1];
                  sa[i]   <= sa[i-1];
                  sb[i]   <= sb[i-1];
               end
            end
         end

         assign last_vld   = vld[LATENCY-1];
         assign last_neg   = sneg[LATENCY-1];
         assign last_op    = sop[LATENCY-1];
         assign last_tag   = stag[LATENCY-1];
         assign last_a     = sa[LATENCY-1];
         assign last_b     = sb[LATENCY-1];
         assign stage_busy = |vld;
      end else begin : g_no_stages
         assign last_vld   = issue;
         assign last_neg   = neg;
         assign last_op    = dec_op;
         assign last_tag   = id_tag;
         assign last_a     = mag_a;
         assign last_b     = mag_b;
         assign stage_busy = 1'b0;
      end
   endgenerate

   logic [2*XLEN-1:0] prod, sprod;
   logic [XLEN-1:0]   res;
   logic              out_vld;

   assign prod  = (2*XLEN)'(last_a) * (2*XLEN)'(last_b);
   assign sprod = last_neg ? -prod : prod;

   always_comb begin
      res = sprod[2*XLEN-1:XLEN];
      case (last_op)
         OP_MUL:  res = sprod[XLEN-1:0];
         OP_MULW: res = XLEN'(signed'(sprod[31:0]));
         default: res = sprod[2*XLEN-1:XLEN];
      endcase
   end

   // Data and tag only load with a new result so they hold after the valid drops
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_vld <= 1'b0;
         mul_r   <= '0;
         mul_tag <= '0;
      end else if (ex_flush) begin
         out_vld <= 1'b0;
      end else if (!ex_stall) begin
         out_vld <= last_vld;
         if (last_vld) begin
            mul_r   <= res;
            mul_tag <= last_tag;
         end
      end
   end

   assign mul_bubble = !out_vld;
   assign mul_busy   = stage_busy | out_vld;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mul_pipe.sv
// ============================================================================
// tb_riscv_mul_pipe : scoreboard bench, random + directed stimulus vs arithmetic model
// Revision 1.0
// ============================================================================
`default_nettype none

`ifndef RV32I
`define RV32I 2'b01
`endif

module tb_riscv_mul_pipe;

   localparam int XLEN  = 64;
   localparam int ILEN  = 64;
   localparam int LAT   = 3;
   localparam int TAG_W = 5;
   localparam logic [1:0] SX64 = 2'b10;
   localparam logic [1:0] SX32 = `RV32I;

   logic             clk;
   logic             rstn;
   logic             ex_stall, ex_flush, id_bubble;
   logic [ILEN-1:0]  id_instr;
   logic [TAG_W-1:0] id_tag;
   logic [XLEN-1:0]  opA, opB;
   logic [1:0]       st_xlen;
   logic             mul_bubble, mul_busy;
   logic [XLEN-1:0]  mul_r;
   logic [TAG_W-1:0] mul_tag;

   riscv_mul_pipe #(.XLEN(XLEN), .ILEN(ILEN), .LATENCY(LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .ex_flush(ex_flush),
      .id_bubble(id_bubble), .id_instr(id_instr), .id_tag(id_tag),
      .opA(opA), .opB(opB), .st_xlen(st_xlen),
      .mul_bubble(mul_bubble), .mul_r(mul_r), .mul_tag(mul_tag), .mul_busy(mul_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]      r;
      logic [TAG_W-1:0] tag;
      int               due;
   } exp_t;

   exp_t             q[$];
   exp_t             e;
   int               adv_cnt = 0;
   bit               last_adv = 0, last_flush = 0;
   bit               cur_acc = 0;
   logic [63:0]      cur_exp = '0;
   bit               shown = 0;
   logic [63:0]      exp_last_r = '0;
   logic [TAG_W-1:0] exp_last_tag = '0;
   int               n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Kinds: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5 some non-multiply instruction
   function automatic logic [ILEN-1:0] mk_instr(input int kind);
      logic [6:0] f7;
      logic [2:0] f3;
      logic [4:0] opc;
      f7 = 7'b0000001; opc = 5'b01100; f3 = 3'(kind);
      if (kind == 4) begin
         opc = 5'b01110; f3 = 3'b000;
      end else if (kind >= 5) begin
         case ($urandom_range(0, 3))
            0:       begin f7 = 7'b0000000; f3 = 3'b000; end
            1:       begin f3 = 3'b100; end
            2:       begin opc = 5'b01110; f3 = 3'b100; end
            default: begin opc = 5'b01101; f3 = 3'b000; end
         endcase
      end
      return {32'($urandom), f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc, 2'b11};
   endfunction

   function automatic logic [63:0] ref_mul(input int kind, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb, ua, ub, p;
      logic [31:0]         w;
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      ua = {64'b0, a};
      ub = {64'b0, b};
      case (kind)
         0: begin p = sa * sb; return p[63:0]; end
         1: begin p = sa * sb; return p[127:64]; end
         2: begin p = sa * ub; return p[127:64]; end
         3: begin p = ua * ub; return p[127:64]; end
         4: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return {64{1'b1}};
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'h7FFF_FFFF_FFFF_FFFF;
         4:       return {32'd0, 32'($urandom)};
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   task automatic drive(input bit bub, input int kind, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tg, input bit stl, input bit fl,
                        input logic [1:0] sx, input logic [63:0] expv);
      @(posedge clk); #1;
      id_bubble = bub;
      id_instr  = mk_instr(kind);
      id_tag    = tg;
      opA       = a;
      opB       = b;
      ex_stall  = stl;
      ex_flush  = fl;
      st_xlen   = sx;
      cur_acc   = !bub && (kind < 4 || (kind == 4 && sx != SX32));
      cur_exp   = expv;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 5, 64'd0, 64'd0, '0, 1'b0, 1'b0, SX64, 64'd0);
   endtask

   task automatic op(input int kind, input logic [63:0] a, input logic [63:0] b,
                     input logic [TAG_W-1:0] tg, input logic [63:0] expv);
      drive(1'b0, kind, a, b, tg, 1'b0, 1'b0, SX64, expv);
   endtask

   // Reference timing: a result is due after LAT non-stalled edges counting its issue edge
   always @(posedge clk) begin
      if (!rstn) begin
         last_adv = 0; last_flush = 0;
      end else if (ex_flush) begin
         q.delete();
         last_adv = 0; last_flush = 1;
      end else if (ex_stall) begin
         last_adv = 0; last_flush = 0;
      end else begin
         adv_cnt++;
         last_adv = 1; last_flush = 0;
         if (cur_acc) q.push_back('{cur_exp, id_tag, adv_cnt + LAT - 1});
      end
   end

   always @(negedge clk) begin
      if (!rstn) begin
         shown = 0;
         chk("rst_bubble", 64'(mul_bubble), 64'd1);
         chk("rst_busy",   64'(mul_busy),   64'd0);
         chk("rst_result", mul_r,           64'd0);
         chk("rst_tag",    64'(mul_tag),    64'd0);
      end else begin
         if (last_adv && !mul_bubble) begin
            if (q.size() == 0) begin
               chk("spurious_result", 64'(mul_bubble), 64'd1);
            end else begin
               e = q.pop_front();
               chk("latency", 64'(adv_cnt), 64'(e.due));
               exp_last_r   = e.r;
               exp_last_tag = e.tag;
            end
            shown = 1;
         end else if (last_adv) begin
            if (q.size() != 0 && q[0].due <= adv_cnt) begin
               chk("missing_result", 64'(mul_bubble), 64'd0);
               void'(q.pop_front());
            end
            shown = 0;
         end else if (last_flush) begin
            chk("flush_bubble", 64'(mul_bubble), 64'd1);
            shown = 0;
         end else begin
            chk("hold_bubble", 64'(mul_bubble), 64'(!shown));
         end
         chk("result", mul_r,        exp_last_r);
         chk("tag",    64'(mul_tag), 64'(exp_last_tag));
         chk("busy",   64'(mul_busy), 64'(q.size() != 0 || shown));
      end
   end

   logic [63:0] ra, rb;
   int          rk;
   bit          rbub, rstl, rfl;
   logic [1:0]  rsx;

   initial begin
      rstn = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0; id_bubble = 1'b1;
      id_instr = '0; id_tag = '0; opA = '0; opB = '0; st_xlen = SX64;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      idle(2);

      op(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7, 64'h4000_0000_0000_0000);
      idle(4);
      op(2, {64{1'b1}}, {64{1'b1}}, 5'd8, {64{1'b1}});
      op(3, {64{1'b1}}, {64{1'b1}}, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE);
      op(4, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE);
      idle(4);
      drive(1'b0, 4, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd11, 1'b0, 1'b0, SX32, 64'd0);
      idle(4);

      op(0, 64'd3, 64'd5, 5'd1, 64'd15);
      op(0, 64'd7, {64{1'b1}}, 5'd2, 64'hFFFF_FFFF_FFFF_FFF9);
      op(0, 64'd0, 64'd9, 5'd3, 64'd0);
      op(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 5'd4, 64'd6);
      idle(5);

      // Stall in flight, then stall again while the result is on the output
      op(0, 64'd6, 64'd7, 5'd12, 64'd42);
      repeat (2) drive(1'b1, 5, 64'd0, 64'd0, '0, 1'b1, 1'b0, SX64, 64'd0);
      idle(2);
      repeat (3) drive(1'b1, 5, 64'd0, 64'd0, '0, 1'b1, 1'b0, SX64, 64'd0);
      idle(4);

      // Flush with two in flight and a same-cycle offer; then flush overriding stall
      op(1, 64'd123, 64'd456, 5'd13, 64'd0);
      op(0, 64'd11, 64'd13, 5'd14, 64'd143);
      drive(1'b0, 0, 64'd2, 64'd2, 5'd15, 1'b0, 1'b1, SX64, 64'd4);
      idle(5);
      op(0, 64'd5, 64'd5, 5'd16, 64'd25);
      drive(1'b1, 5, 64'd0, 64'd0, '0, 1'b1, 1'b0, SX64, 64'd0);
      drive(1'b1, 5, 64'd0, 64'd0, '0, 1'b1, 1'b1, SX64, 64'd0);
      idle(5);

      // Asynchronous reset pulse with work in flight
      op(0, 64'd9, 64'd9, 5'd17, 64'd81);
      op(0, 64'd8, 64'd8, 5'd18, 64'd64);
      op(0, 64'd7, 64'd7, 5'd19, 64'd49);
      @(posedge clk); #2;
      rstn = 1'b0; cur_acc = 0; id_bubble = 1'b1; ex_stall = 1'b0; ex_flush = 1'b0;
      #1;
      chk("async_rst_bubble", 64'(mul_bubble), 64'd1);
      chk("async_rst_busy",   64'(mul_busy),   64'd0);
      chk("async_rst_result", mul_r,           64'd0);
      chk("async_rst_tag",    64'(mul_tag),    64'd0);
      q.delete(); exp_last_r = '0; exp_last_tag = '0; shown = 0;
      @(posedge clk); #2 rstn = 1'b1;
      op(3, 64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0, 5'd20,
         ref_mul(3, 64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0));
      idle(4);

      for (int i = 0; i < 800; i++) begin
         rk   = $urandom_range(0, 5);
         ra   = pick();
         rb   = pick();
         rbub = ($urandom_range(0, 9) < 3);
         rstl = ($urandom_range(0, 9) == 0);
         rfl  = ($urandom_range(0, 39) == 0);
         rsx  = ($urandom_range(0, 7) == 0) ? SX32 : SX64;
         drive(rbub, rk, ra, rb, 5'($urandom), rstl, rfl, rsx, ref_mul(rk, ra, rb));
      end
      idle(LAT + 3);
      chk("drain_queue_empty", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/riscv_mul_pipe.md
# riscv_mul_pipe

Fully pipelined RISC-V M-extension multiplier for the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/MULW per cycle with a configurable latency and never stalls the pipeline. Each result carries its destination tag to write-back. In-flight operations can be killed by a flush. It plugs into the same execute-stage slot, and behind the same WB result mux, as the iterative multiplier.

## Interface
- XLEN, 64, data width (32 or 64); MULW is decoded only when XLEN=64
- ILEN, 64, instruction width (≥32)
- LATENCY, 2, issue-to-result cycles, legal 1..4; elaboration error outside that range
- TAG_W, 5, destination tag width
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- ex_stall  in  1  freezes every stage and the output registers
- ex_flush  in  1  kills all in-flight operations and the current issue
- id_bubble  in  1  1 = no instruction offered
- id_instr  in  ILEN  instruction; uses [31:25], [14:12], [6:2]
- id_tag  in  TAG_W  destination tag of the offered instruction
- opA, opB  in  XLEN  source operands
- st_xlen  in  2  current XLEN mode; `RV32I = 32-bit
- mul_bubble  out  1  0 = mul_r/mul_tag valid this cycle
- mul_r  out  XLEN  result
- mul_tag  out  TAG_W  tag of mul_r
- mul_busy  out  1  any stage holds a valid operation

## Operation
- Decode: func7=0000001 and one of:
  - opcode 01100, func3 000 → MUL
  - opcode 01100, func3 001 → MULH
  - opcode 01100, func3 010 → MULHSU
  - opcode 01100, func3 011 → MULHU
  - opcode 01110, func3 000 → MULW, only when XLEN=64 and st_xlen != `RV32I
  - anything else is not a multiply
- Issue: accepted when !id_bubble && is_mul && !ex_stall && !ex_flush. No ready signal; every valid offer is taken.
- Single unsigned XLEN×XLEN multiplier on magnitudes:
  - MUL/MULH: |A|·|B|, negate if A[XLEN-1]^B[XLEN-1]
  - MULHSU: |A|·B, negate if A[XLEN-1]
  - MULHU: A·B, no negate
  - MULW: |sext32(A[31:0])|·|sext32(B[31:0])|, negate if A[31]^B[31]
- Negation is two's complement over 2·XLEN bits.
- Result select:
  - MUL: product[XLEN-1:0]
  - MULH/MULHSU/MULHU: product[2XLEN-1:XLEN]
  - MULW: sext32(product[31:0])
- Per-stage valid bit, op and tag travel with the data. Register placement inside the pipeline is free; only the cycle contract below binds.
- mul_busy = OR of all stage valid bits, including the output register.

## Timing
- Reset (async, immediate):
  - all valid bits 0
  - mul_bubble=1, mul_r=0, mul_tag=0, mul_busy=0
- Latency: an instruction issued in cycle N gives mul_bubble=0 with mul_r/mul_tag in cycle N+LATENCY, given no stalls.
- Throughput: one per cycle. Back-to-back issues return on consecutive cycles, in order.
- Without a new result, mul_bubble returns to 1 after one cycle. mul_r/mul_tag hold their last value.
- ex_stall=1:
  - no stage advances; outputs hold, including mul_bubble=0 if set
  - each stall cycle adds one cycle to every in-flight result
- ex_flush=1:
  - all valid bits clear at the next edge, so mul_bubble=1 and mul_busy=0 the cycle after
  - the same-cycle offer is not accepted
  - flush overrides stall
  - a result already showing mul_bubble=0 in the flush cycle has been delivered, and is dropped at the edge
- st_xlen change while an op is in flight: in-flight ops are unaffected; decode uses st_xlen at issue.
- Reset during an operation discards everything; the first issue after rstn rises behaves as from idle.

## Test plan
- XLEN=64, LATENCY=3:
  - MULH with A=B=0x8000000000000000 issued in cycle N → mul_bubble=0 in N+3, mul_r=0x4000000000000000, tag echoed.
- MULHSU with A=0xFFFFFFFFFFFFFFFF, B=0xFFFFFFFFFFFFFFFF → mul_r=0xFFFFFFFFFFFFFFFF.
- MULHU with the same operands → mul_r=0xFFFFFFFFFFFFFFFE.
- MULW with A=0x000000007FFFFFFF, B=2 → mul_r=0xFFFFFFFFFFFFFFFE.
- MULW with st_xlen=`RV32I → never accepted, mul_busy stays 0.
- Four back-to-back MULs (3×5, 7×−1, 0×9, −2×−3) with tags 1..4 → results 15, 0xFFFFFFFFFFFFFFF9, 0, 6 in N+3..N+6, tags 1..4.
- Issue in N, ex_stall high in N+1 and N+2 → result in N+5; with ex_stall held at result time, mul_bubble=0 and the data hold until stall drops.
- Two ops in flight, then ex_flush:
  - no further mul_bubble=0
  - mul_busy=0 the cycle after the flush
  - rstn pulsed mid-operation → all outputs at their reset values immediately.
